// File: rtl/memctrl_pkg.sv
// Shared constants and lane helpers for the load/store byte-lane adapter.
// The memory_controller top optionally traps misaligned accesses when MEMCTRL_MISALIGN_TRAP_EN is defined.
package memctrl_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [1:0] LEN_BYTE = 2'b00;
    localparam logic [1:0] LEN_HALF = 2'b01;
    localparam logic [1:0] LEN_WORD = 2'b10;

    // Write-enable mask for an access; bits shifted past lane 3 are dropped, so nothing wraps.
    function automatic logic [3:0] byteMask(input logic [1:0] length, input logic [1:0] off);
        logic [3:0] base;
        case (length)
            LEN_BYTE: base = 4'b0001;
            LEN_HALF: base = 4'b0011;
            default:  base = 4'b1111;
        endcase
        return base << off;
    endfunction

    // Reserved length code 11 behaves like a word.
    function automatic logic isMisaligned(input logic [1:0] length, input logic [1:0] off);
        case (length)
            LEN_BYTE: return 1'b0;
            LEN_HALF: return (off == 2'd3);
            default:  return (off != 2'd0);
        endcase
    endfunction

endpackage

// File: rtl/load_extractor.sv
// Combinational load-data path: realigns the addressed sub-word of the RAM word
// and zero- or sign-extends it according to the captured load context.
module load_extractor
    import memctrl_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] ramData,
    input  logic [1:0]            ctxOff,
    input  logic [1:0]            ctxLength,
    input  logic                  ctxUnsigned,
    output logic [DATA_WIDTH-1:0] dataOut
);

    logic [DATA_WIDTH-1:0] shifted;
    logic                  fillBit;

    // Logical shift: bytes above a misaligned access read as zero before extension.
    assign shifted = ramData >> {ctxOff, 3'b000};

    always_comb begin
        dataOut = shifted;
        fillBit = 1'b0;
        case (ctxLength)
            LEN_BYTE: begin
                fillBit = ~ctxUnsigned & shifted[7];
                dataOut = {{24{fillBit}}, shifted[7:0]};
            end
            LEN_HALF: begin
                fillBit = ~ctxUnsigned & shifted[15];
                dataOut = {{16{fillBit}}, shifted[15:0]};
            end
            default: dataOut = shifted;
        endcase
    end

endmodule

// File: rtl/memory_controller.sv
// Byte-lane adapter between the load/store unit and a 32-bit word RAM with byte enables.
// Define MEMCTRL_MISALIGN_TRAP_EN to block misaligned requests and flag them on misalignedAccess.
module memory_controller
    import memctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] addressIn,
    input  logic [DATA_WIDTH-1:0] dataWriteIn,
    input  logic [1:0]            length,
    input  logic                  storeIn,
    input  logic                  loadIn,
    input  logic                  loadUnsigned,
    output logic [DATA_WIDTH-1:0] dataReadOut,
    input  logic [DATA_WIDTH-1:0] ramDataRead,
    output logic [DATA_WIDTH-1:0] addressOut,
    output logic [DATA_WIDTH-1:0] ramDataWrite,
    output logic [3:0]            byteSelect,
    output logic                  ramStore,
    output logic                  ramLoad
`ifdef MEMCTRL_MISALIGN_TRAP_EN
    ,
    output logic                  misalignedAccess
`endif
);

    logic [1:0]            off;
    logic                  blocked;
    logic [1:0]            ctxOffReg;
    logic [1:0]            ctxLengthReg;
    logic                  ctxUnsignedReg;
    logic [DATA_WIDTH-1:0] extracted;

    assign off = addressIn[1:0];

`ifdef MEMCTRL_MISALIGN_TRAP_EN
    assign blocked          = isMisaligned(length, off);
    assign misalignedAccess = reset & (storeIn | loadIn) & blocked;
`else
    assign blocked = 1'b0;
`endif

    // A store takes priority over a simultaneous load; reset low silences both strobes.
    assign ramStore     = reset & storeIn & ~blocked;
    assign ramLoad      = reset & loadIn & ~storeIn & ~blocked;
    assign byteSelect   = ramStore ? byteMask(length, off) : 4'b0000;
    assign ramDataWrite = dataWriteIn << {off, 3'b000};
    assign addressOut   = addressIn;

    // Context defaults to an aligned signed word so the RAM word passes through before any load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctxOffReg      <= 2'd0;
            ctxLengthReg   <= LEN_WORD;
            ctxUnsignedReg <= 1'b0;
        end else if (ramLoad) begin
            ctxOffReg      <= off;
            ctxLengthReg   <= length;
            ctxUnsignedReg <= loadUnsigned;
        end
    end

    load_extractor uExtractor (
        .ramData     (ramDataRead),
        .ctxOff      (ctxOffReg),
        .ctxLength   (ctxLengthReg),
        .ctxUnsigned (ctxUnsignedReg),
        .dataOut     (extracted)
    );

    assign dataReadOut = reset ? extracted : '0;

endmodule

// File: tb/tb_memory_controller.sv
// Directed self-checking bench for memory_controller: stores, back-to-back loads,
// store/load priority, asynchronous reset mid-load and misaligned handling.
module tb_memory_controller;
    import memctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addressIn;
    logic [31:0] dataWriteIn;
    logic [1:0]  length;
    logic        storeIn;
    logic        loadIn;
    logic        loadUnsigned;
    logic [31:0] dataReadOut;
    logic [31:0] ramDataRead;
    logic [31:0] addressOut;
    logic [31:0] ramDataWrite;
    logic [3:0]  byteSelect;
    logic        ramStore;
    logic        ramLoad;
`ifdef MEMCTRL_MISALIGN_TRAP_EN
    logic        misalignedAccess;
`endif

    int checks = 0;
    int errors = 0;

    memory_controller dut (
        .clk          (clk),
        .reset        (reset),
        .addressIn    (addressIn),
        .dataWriteIn  (dataWriteIn),
        .length       (length),
        .storeIn      (storeIn),
        .loadIn       (loadIn),
        .loadUnsigned (loadUnsigned),
        .dataReadOut  (dataReadOut),
        .ramDataRead  (ramDataRead),
        .addressOut   (addressOut),
        .ramDataWrite (ramDataWrite),
        .byteSelect   (byteSelect),
        .ramStore     (ramStore),
        .ramLoad      (ramLoad)
`ifdef MEMCTRL_MISALIGN_TRAP_EN
        ,
        .misalignedAccess (misalignedAccess)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h expected=%08h", tag, got, exp);
        end else begin
            $display("ok   %s = %08h", tag, got);
        end
    endtask

    task automatic request(input logic st, input logic ld, input logic [31:0] addr,
                           input logic [31:0] data, input logic [1:0] len, input logic uns);
        storeIn      = st;
        loadIn       = ld;
        addressIn    = addr;
        dataWriteIn  = data;
        length       = len;
        loadUnsigned = uns;
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b0;
        ramDataRead = 32'hFFFF_FFFF;
        request(1'b1, 1'b1, 32'h103, 32'hAB, LEN_BYTE, 1'b0);
        @(negedge clk);
        checkValue("rst_ramStore", {31'd0, ramStore}, 32'd0);
        checkValue("rst_ramLoad", {31'd0, ramLoad}, 32'd0);
        checkValue("rst_byteSelect", {28'd0, byteSelect}, 32'd0);
        checkValue("rst_dataReadOut", dataReadOut, 32'd0);

        nextCycle();
        request(1'b0, 1'b0, 32'h0, 32'h0, LEN_WORD, 1'b0);
        reset       = 1'b1;
        ramDataRead = 32'h1234_5678;
        @(negedge clk);
        checkValue("post_rst_passthru", dataReadOut, 32'h1234_5678);
        checkValue("idle_byteSelect", {28'd0, byteSelect}, 32'd0);

        // Stores are purely combinational.
        nextCycle();
        request(1'b1, 1'b0, 32'h103, 32'h0000_00AB, LEN_BYTE, 1'b0);
        @(negedge clk);
        checkValue("stb_byteSelect", {28'd0, byteSelect}, 32'h8);
        checkValue("stb_ramDataWrite", ramDataWrite, 32'hAB00_0000);
        checkValue("stb_addressOut", addressOut, 32'h103);
        checkValue("stb_ramStore", {31'd0, ramStore}, 32'd1);

        nextCycle();
        request(1'b1, 1'b0, 32'h102, 32'h0000_BEEF, LEN_HALF, 1'b0);
        @(negedge clk);
        checkValue("sth_byteSelect", {28'd0, byteSelect}, 32'hC);
        checkValue("sth_ramDataWrite", ramDataWrite, 32'hBEEF_0000);

        nextCycle();
        request(1'b1, 1'b0, 32'h100, 32'hCAFE_F00D, LEN_WORD, 1'b0);
        @(negedge clk);
        checkValue("stw_byteSelect", {28'd0, byteSelect}, 32'hF);
        checkValue("stw_ramDataWrite", ramDataWrite, 32'hCAFE_F00D);

        // Back-to-back loads; each result is checked one cycle after its request.
        nextCycle();
        request(1'b0, 1'b1, 32'h101, 32'h0, LEN_BYTE, 1'b0);
        @(negedge clk);
        checkValue("ldb_ramLoad", {31'd0, ramLoad}, 32'd1);

        nextCycle();
        request(1'b0, 1'b1, 32'h101, 32'h0, LEN_BYTE, 1'b1);
        ramDataRead = 32'h1234_8056;
        @(negedge clk);
        checkValue("ldb_signed", dataReadOut, 32'hFFFF_FF80);
        checkValue("ldbu_ramLoad", {31'd0, ramLoad}, 32'd1);

        nextCycle();
        request(1'b0, 1'b1, 32'h102, 32'h0, LEN_HALF, 1'b0);
        ramDataRead = 32'h1234_8056;
        @(negedge clk);
        checkValue("ldb_unsigned", dataReadOut, 32'h0000_0080);

        nextCycle();
        request(1'b0, 1'b1, 32'h100, 32'h0, LEN_WORD, 1'b0);
        ramDataRead = 32'h9ABC_0000;
        @(negedge clk);
        checkValue("ldh_signed", dataReadOut, 32'hFFFF_9ABC);

        nextCycle();
        request(1'b0, 1'b0, 32'h0, 32'h0, LEN_WORD, 1'b0);
        ramDataRead = 32'h9ABC_0000;
        @(negedge clk);
        checkValue("ldw", dataReadOut, 32'h9ABC_0000);

        // Store wins; a captured byte context at off 3 would return 0x00000012 instead.
        nextCycle();
        request(1'b1, 1'b1, 32'h103, 32'h0000_00AB, LEN_BYTE, 1'b1);
        @(negedge clk);
        checkValue("both_ramStore", {31'd0, ramStore}, 32'd1);
        checkValue("both_ramLoad", {31'd0, ramLoad}, 32'd0);
        nextCycle();
        request(1'b0, 1'b0, 32'h0, 32'h0, LEN_WORD, 1'b0);
        ramDataRead = 32'h1234_8056;
        @(negedge clk);
        checkValue("both_ctx_kept", dataReadOut, 32'h1234_8056);

        // Misaligned half load at off 3 truncates: upper byte reads 0, so no sign fill.
        nextCycle();
        request(1'b0, 1'b1, 32'h103, 32'h0, LEN_HALF, 1'b0);
`ifdef MEMCTRL_MISALIGN_TRAP_EN
        @(negedge clk);
        checkValue("trap_half_ramLoad", {31'd0, ramLoad}, 32'd0);
        checkValue("trap_half_flag", {31'd0, misalignedAccess}, 32'd1);
`endif
        nextCycle();
        request(1'b0, 1'b0, 32'h0, 32'h0, LEN_WORD, 1'b0);
        ramDataRead = 32'h80FF_0000;
        @(negedge clk);
`ifdef MEMCTRL_MISALIGN_TRAP_EN
        checkValue("trap_half_ctx_kept", dataReadOut, 32'h80FF_0000);
`else
        checkValue("mis_ldh_trunc", dataReadOut, 32'h0000_0080);
`endif

        // Capture a byte context, then assert reset during the next load request.
        nextCycle();
        request(1'b0, 1'b1, 32'h101, 32'h0, LEN_BYTE, 1'b1);
        nextCycle();
        request(1'b0, 1'b1, 32'h102, 32'h0, LEN_HALF, 1'b0);
        ramDataRead = 32'h1234_8056;
        #2;
        checkValue("pre_rst_ldbu", dataReadOut, 32'h0000_0080);
        reset = 1'b0;
        #1;
        checkValue("midrst_ramLoad", {31'd0, ramLoad}, 32'd0);
        checkValue("midrst_dataReadOut", dataReadOut, 32'd0);
        nextCycle();
        reset = 1'b1;
        request(1'b0, 1'b0, 32'h0, 32'h0, LEN_WORD, 1'b0);
        @(negedge clk);
        checkValue("midrst_ctx_cleared", dataReadOut, 32'h1234_8056);

`ifdef MEMCTRL_MISALIGN_TRAP_EN
        nextCycle();
        request(1'b0, 1'b1, 32'h102, 32'h0, LEN_WORD, 1'b0);
        @(negedge clk);
        checkValue("trap_word_flag", {31'd0, misalignedAccess}, 32'd1);
        checkValue("trap_word_ramLoad", {31'd0, ramLoad}, 32'd0);
        nextCycle();
        request(1'b1, 1'b0, 32'h103, 32'h0000_BEEF, LEN_HALF, 1'b0);
        @(negedge clk);
        checkValue("trap_sth_byteSelect", {28'd0, byteSelect}, 32'd0);
        checkValue("trap_sth_ramStore", {31'd0, ramStore}, 32'd0);
`else
        nextCycle();
        request(1'b1, 1'b0, 32'h103, 32'h0000_BEEF, LEN_HALF, 1'b0);
        @(negedge clk);
        checkValue("mis_sth_byteSelect", {28'd0, byteSelect}, 32'h8);
        checkValue("mis_sth_ramDataWrite", ramDataWrite, 32'hEF00_0000);
`endif

        nextCycle();
        request(1'b0, 1'b0, 32'h0, 32'h0, LEN_WORD, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
